rf_wb_port_sched: RTL and testbench

//  Schedules up to NUM_REQ writeback requesters onto the 4 write ports of the 4W1R register-file RAM.

---
 rtl/rf_sched_pkg.sv | 16 +
 rtl/rf_sched_pick.sv | 59 +++++
 rtl/rf_wb_port_sched.sv | 187 ++++++++++++++++++
 tb/tb_rf_wb_port_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file writeback port scheduler.
package rf_sched_pkg;

  // Number of RAM write ports the scheduler drives.
  localparam int NUM_WP = 4;

  // Scheduler FSM states.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } sched_state_e;

  // Index of one write port (0..NUM_WP-1).
  typedef logic [1:0] port_idx_t;

endpackage

// File: rtl/rf_sched_pick.sv
// Combinational round-robin pick: walks requesters starting at rr_ptr and
// hands out up to NUM_WP grants, skipping any requester whose address is
// already taken this cycle. The k-th grant in scan order lands on port k.
module rf_sched_pick
  import rf_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 6
) (
  input  logic [NUM_REQ-1:0]               valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
  input  logic [$clog2(NUM_REQ)-1:0]       rr_ptr,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_WP-1:0][NUM_REQ-1:0]   port_sel,
  output logic [NUM_WP-1:0]                port_vld
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0]                 addr_a [NUM_REQ];
  logic [NUM_WP-1:0][ADDR_WIDTH-1:0]     taken_addr;
  logic [2:0]                            n_gnt;
  logic [PTR_W:0]                        pos;
  logic [PTR_W-1:0]                      idx;
  logic                                  clash;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Scan in rotated order, granting while ports remain and the address is new.
  always_comb begin
    grant      = '0;
    port_sel   = '0;
    port_vld   = '0;
    taken_addr = '0;
    n_gnt      = '0;
    pos        = '0;
    idx        = '0;
    clash      = 1'b0;
    for (int s = 0; s < NUM_REQ; s++) begin
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(s);
      if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
      idx   = pos[PTR_W-1:0];
      clash = 1'b0;
      for (int k = 0; k < NUM_WP; k++) begin
        if (port_vld[k] && (taken_addr[k] == addr_a[idx])) clash = 1'b1;
      end
      if (valid[idx] && (n_gnt < 3'(NUM_WP)) && !clash) begin
        grant[idx]                  = 1'b1;
        port_sel[n_gnt[1:0]][idx]   = 1'b1;
        port_vld[n_gnt[1:0]]        = 1'b1;
        taken_addr[n_gnt[1:0]]      = addr_a[idx];
        n_gnt                       = n_gnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_port_sched.sv
// Writeback port scheduler for the 4W1R register file: maps up to NUM_REQ
// writeback requesters onto the four RAM write ports with rotating priority
// and no same-address collisions. Optional post-reset zero sweep of the RAM
// is enabled by defining RF_SCHED_CLEAR_EN.
//
// Handshake: requester i transfers in a cycle where req_valid[i] & req_ready[i].
// Once raised, req_valid/req_addr/req_data hold until accepted. req_ready is
// combinational from req_valid, req_addr and rr_ptr, and is 0 whenever
// req_valid is 0, during rst, and while the clear sweep runs. An accepted
// write appears on its port's registered we/waddr/wdata one cycle later.
module rf_wb_port_sched
  import rf_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          we1,
  output logic                          we2,
  output logic                          we3,
  output logic                          we4,
  output logic [ADDR_WIDTH-1:0]         waddr1,
  output logic [ADDR_WIDTH-1:0]         waddr2,
  output logic [ADDR_WIDTH-1:0]         waddr3,
  output logic [ADDR_WIDTH-1:0]         waddr4,
  output logic [DATA_WIDTH-1:0]         wdata1,
  output logic [DATA_WIDTH-1:0]         wdata2,
  output logic [DATA_WIDTH-1:0]         wdata3,
  output logic [DATA_WIDTH-1:0]         wdata4,
  output logic                          busy,
  output logic                          dbg_state,
  output logic [2:0]                    dbg_rr_ptr
);

  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_CLEAR = CLEAR;
  localparam logic [0:0] ST_RUN   = RUN;
`ifdef RF_SCHED_CLEAR_EN
  localparam logic [0:0] RST_STATE = ST_CLEAR;
`else
  localparam logic [0:0] RST_STATE = ST_RUN;
`endif

  logic [0:0]                          state, state_n;
  logic [PTR_W-1:0]                    rr_ptr, rr_next, last_src;
  port_idx_t                           last_port;
  logic [NUM_REQ-1:0]                  grant;
  logic [NUM_WP-1:0][NUM_REQ-1:0]      port_sel;
  logic [NUM_WP-1:0]                   port_vld;
  logic [NUM_WP-1:0][ADDR_WIDTH-1:0]   port_addr;
  logic [NUM_WP-1:0][DATA_WIDTH-1:0]   port_data;
  logic [NUM_WP-1:0]                   we_q;
  logic [NUM_WP-1:0][ADDR_WIDTH-1:0]   waddr_q;
  logic [NUM_WP-1:0][DATA_WIDTH-1:0]   wdata_q;
  logic [ADDR_WIDTH-1:0]               addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]               data_a [NUM_REQ];
  logic                                run_ok;
`ifdef RF_SCHED_CLEAR_EN
  logic [ADDR_WIDTH-1:0]               clr_cnt;
  logic                                busy_q;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rf_sched_pick #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REQ    (NUM_REQ)
  ) u_pick (
    .valid    (req_valid),
    .addr     (req_addr),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .port_sel (port_sel),
    .port_vld (port_vld)
  );

  // Grants only become accepts when running and not being reset.
  assign run_ok    = (state != ST_CLEAR) && !rst;
  assign req_ready = run_ok ? grant : '0;

  // Route each port's selected requester address/data (one-hot OR mux).
  always_comb begin
    port_addr = '0;
    port_data = '0;
    for (int k = 0; k < NUM_WP; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (port_sel[k][i]) begin
          port_addr[k] = port_addr[k] | addr_a[i];
          port_data[k] = port_data[k] | data_a[i];
        end
      end
    end
  end

  // Next priority pointer: one past the requester on the highest used port.
  always_comb begin
    last_port = '0;
    for (int k = 0; k < NUM_WP; k++) begin
      if (port_vld[k]) last_port = port_idx_t'(k);
    end
    last_src = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (port_sel[last_port][i]) last_src = PTR_W'(i);
    end
    rr_next = (last_src == PTR_W'(NUM_REQ-1)) ? '0 : last_src + PTR_W'(1);
  end

  // FSM next state: the sweep ends after the last address is issued.
  always_comb begin
    state_n = state;
`ifdef RF_SCHED_CLEAR_EN
    if ((state == ST_CLEAR) && (clr_cnt == '1)) state_n = ST_RUN;
`else
    state_n = ST_RUN;
`endif
  end

  // State, pointer, sweep counter and registered RAM write ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RST_STATE;
      rr_ptr  <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef RF_SCHED_CLEAR_EN
      clr_cnt <= '0;
      busy_q  <= 1'b1;
`endif
    end else begin
      state <= state_n;
`ifdef RF_SCHED_CLEAR_EN
      busy_q <= (state_n == ST_CLEAR);
`endif
      if (state == ST_RUN) begin
        we_q    <= port_vld;
        waddr_q <= port_addr;
        wdata_q <= port_data;
        if (|port_vld) rr_ptr <= rr_next;
      end else begin
`ifdef RF_SCHED_CLEAR_EN
        we_q    <= NUM_WP'(1);
        waddr_q <= {{((NUM_WP-1)*ADDR_WIDTH){1'b0}}, clr_cnt};
        wdata_q <= '0;
        clr_cnt <= clr_cnt + 1'b1;
`else
        we_q    <= '0;
        waddr_q <= '0;
        wdata_q <= '0;
`endif
      end
    end
  end

`ifdef RF_SCHED_CLEAR_EN
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign we1    = we_q[0];
  assign we2    = we_q[1];
  assign we3    = we_q[2];
  assign we4    = we_q[3];
  assign waddr1 = waddr_q[0];
  assign waddr2 = waddr_q[1];
  assign waddr3 = waddr_q[2];
  assign waddr4 = waddr_q[3];
  assign wdata1 = wdata_q[0];
  assign wdata2 = wdata_q[1];
  assign wdata3 = wdata_q[2];
  assign wdata4 = wdata_q[3];

  assign dbg_state  = state;
  assign dbg_rr_ptr = 3'(rr_ptr);

endmodule

// File: tb/tb_rf_wb_port_sched.sv
// Self-checking bench for rf_wb_port_sched (default parameters).
// Honours RF_SCHED_CLEAR_EN the same way the design does.
module tb_rf_wb_port_sched;

  localparam int N    = 6;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int SLOT = 1 + AW + DW;
  localparam int PW   = 4 * SLOT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            we1, we2, we3, we4;
  logic [AW-1:0]   waddr1, waddr2, waddr3, waddr4;
  logic [DW-1:0]   wdata1, wdata2, wdata3, wdata4;
  logic            busy;
  logic            dbg_state;
  logic [2:0]      dbg_rr_ptr;

  rf_wb_port_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .we1(we1), .we2(we2), .we3(we3), .we4(we4),
    .waddr1(waddr1), .waddr2(waddr2), .waddr3(waddr3), .waddr4(waddr4),
    .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3), .wdata4(wdata4),
    .busy(busy), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

`ifdef RF_SCHED_CLEAR_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  // ---------------- requester state + reference model ----------------
  logic          bv [N];
  logic [AW-1:0] ba [N];
  logic [DW-1:0] bd [N];
  int            m_rr;
  logic [N-1:0]  last_rdy_dut;
  logic [PW-1:0] exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = bv[i];
      req_addr[i*AW +: AW]  = ba[i];
      req_data[i*DW +: DW]  = bd[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      bv[i] = 1'b0;
      ba[i] = '0;
      bd[i] = '0;
    end
    drive_inputs();
  endtask

  function automatic logic [PW-1:0] out_word();
    return {we4, waddr4, wdata4, we3, waddr3, wdata3,
            we2, waddr2, wdata2, we1, waddr1, wdata1};
  endfunction

`ifdef RF_SCHED_CLEAR_EN
  // Follow the post-reset zero sweep; entered at the first sample after rst.
  task automatic wait_sweep();
    int busy_cnt;
    int next_addr;
    bit done;
    busy_cnt  = 0;
    next_addr = 0;
    done      = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (busy) busy_cnt++;
      if (we1) begin
        n_cmp++;
        if (waddr1 !== AW'(next_addr) || wdata1 !== '0 || {we2, we3, we4} !== 3'b000) begin
          n_err++;
          $display("FAIL sweep_write: got addr=%0d data=%h we2..4=%b, want addr=%0d data=0 we2..4=000",
                   waddr1, wdata1, {we2, we3, we4}, next_addr);
        end
        next_addr++;
      end else if (!busy) begin
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (busy_cnt != 32) begin
      n_err++;
      $display("FAIL sweep_busy_cycles: got %0d want 32", busy_cnt);
    end
    n_cmp++;
    if (next_addr != 32) begin
      n_err++;
      $display("FAIL sweep_addr_count: got %0d want 32", next_addr);
    end
  endtask
`endif

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    m_rr = 0;
`ifdef RF_SCHED_CLEAR_EN
    wait_sweep();
`endif
  endtask

  // One RUN cycle: model picks from the requester table, the DUT's ready
  // and next-cycle port outputs are scored, granted requesters retire.
  task automatic cycle();
    int            order [$];
    logic [AW-1:0] used [$];
    logic [N-1:0]  exp_rdy;
    logic [PW-1:0] exp_w;
    logic [PW-1:0] got_w;
    int            i;
    bit            clash;
    drive_inputs();
    exp_rdy = '0;
    for (int s = 0; s < N; s++) begin
      i     = (m_rr + s) % N;
      clash = 1'b0;
      foreach (used[u]) if (used[u] == ba[i]) clash = 1'b1;
      if (bv[i] && order.size() < 4 && !clash) begin
        order.push_back(i);
        used.push_back(ba[i]);
        exp_rdy[i] = 1'b1;
      end
    end
    exp_w = '0;
    foreach (order[k]) exp_w[k*SLOT +: SLOT] = {1'b1, ba[order[k]], bd[order[k]]};
    exp_q.push_back(exp_w);
    #1;
    last_rdy_dut = req_ready;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL req_ready: got %b want %b (rr=%0d)", req_ready, exp_rdy, m_rr);
    end
    @(posedge clk); #1;
    got_w = out_word();
    exp_w = exp_q.pop_front();
    n_cmp++;
    if (got_w !== exp_w) begin
      n_err++;
      $display("FAIL write_ports: got %h want %h", got_w, exp_w);
    end
    n_cmp++;
    if ((we1 && we2 && waddr1 == waddr2) || (we1 && we3 && waddr1 == waddr3) ||
        (we1 && we4 && waddr1 == waddr4) || (we2 && we3 && waddr2 == waddr3) ||
        (we2 && we4 && waddr2 == waddr4) || (we3 && we4 && waddr3 == waddr4)) begin
      n_err++;
      $display("FAIL distinct_addr: got %0d/%0d/%0d/%0d we=%b want all distinct",
               waddr1, waddr2, waddr3, waddr4, {we4, we3, we2, we1});
    end
    if (order.size() > 0) m_rr = (order[order.size()-1] + 1) % N;
    n_cmp++;
    if (dbg_rr_ptr !== 3'(m_rr)) begin
      n_err++;
      $display("FAIL rr_ptr: got %0d want %0d", dbg_rr_ptr, m_rr);
    end
    foreach (order[k]) bv[order[k]] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      bv[i] = 1'b1;
      ba[i] = AW'(i);
      bd[i] = 32'hA000_0000 + i;
    end
    drive_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 000000", req_ready);
    end
    clear_reqs();
    rst  = 1'b0;
    m_rr = 0;
    n_cmp++;
    if (out_word() !== '0) begin
      n_err++;
      $display("FAIL reset_ports: got %h want 0", out_word());
    end
    n_cmp++;
    if (dbg_rr_ptr !== 3'd0) begin
      n_err++;
      $display("FAIL reset_rr: got %0d want 0", dbg_rr_ptr);
    end
    n_cmp++;
    if (busy !== EXP_BUSY_RST) begin
      n_err++;
      $display("FAIL reset_busy: got %b want %b", busy, EXP_BUSY_RST);
    end
`ifdef RF_SCHED_CLEAR_EN
    wait_sweep();
`endif
    n_cmp++;
    if (dbg_state !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL run_state: got state=%b busy=%b want state=1 busy=0", dbg_state, busy);
    end
  endtask

  task automatic test_distinct();
    do_reset();
    for (int i = 0; i < N; i++) begin
      bv[i] = 1'b1;
      ba[i] = AW'(10 + i);
      bd[i] = $urandom;
    end
    cycle();
    n_cmp++;
    if (last_rdy_dut !== 6'b001111 || dbg_rr_ptr !== 3'd4) begin
      n_err++;
      $display("FAIL distinct_first: got ready=%b rr=%0d want ready=001111 rr=4", last_rdy_dut, dbg_rr_ptr);
    end
    cycle();
    n_cmp++;
    if (last_rdy_dut !== 6'b110000 || {we4, we3, we2, we1} !== 4'b0011) begin
      n_err++;
      $display("FAIL distinct_second: got ready=%b we=%b want ready=110000 we=0011",
               last_rdy_dut, {we4, we3, we2, we1});
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    bv[1] = 1'b1; ba[1] = 5'd7; bd[1] = 32'h1111_0001;
    bv[2] = 1'b1; ba[2] = 5'd7; bd[2] = 32'h2222_0002;
    cycle();
    n_cmp++;
    if (last_rdy_dut !== 6'b000010 || waddr1 !== 5'd7 || wdata1 !== 32'h1111_0001) begin
      n_err++;
      $display("FAIL same_addr_first: got ready=%b addr=%0d data=%h want 000010 7 11110001",
               last_rdy_dut, waddr1, wdata1);
    end
    cycle();
    n_cmp++;
    if (last_rdy_dut !== 6'b000100 || waddr1 !== 5'd7 || wdata1 !== 32'h2222_0002 || we2 !== 1'b0) begin
      n_err++;
      $display("FAIL same_addr_second: got ready=%b addr=%0d data=%h we2=%b want 000100 7 22220002 0",
               last_rdy_dut, waddr1, wdata1, we2);
    end
  endtask

  task automatic test_starvation();
    int waited;
    bit got5;
    do_reset();
    bv[5] = 1'b1; ba[5] = 5'd20; bd[5] = 32'h5555_5555;
    waited = 0;
    got5   = 1'b0;
    for (int c = 0; c < 4 && !got5; c++) begin
      for (int i = 0; i < 5; i++) begin
        bv[i] = 1'b1;
        ba[i] = AW'(i);
        bd[i] = $urandom;
      end
      cycle();
      waited++;
      if (last_rdy_dut[5]) got5 = 1'b1;
    end
    n_cmp++;
    if (!got5 || waited > 2) begin
      n_err++;
      $display("FAIL starvation: got accepted=%b after %0d cycles want accepted within 2", got5, waited);
    end
    clear_reqs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bv[i] && $urandom_range(0, 99) < 60) begin
          bv[i] = 1'b1;
          ba[i] = (c < 150) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
          bd[i] = $urandom;
        end
      end
      cycle();
    end
    clear_reqs();
  endtask

  task automatic test_back_to_back_reset();
    clear_reqs();
    for (int i = 0; i < 4; i++) begin
      bv[i] = 1'b1;
      ba[i] = AW'(24 + i);
      bd[i] = $urandom;
    end
    cycle();
    for (int i = 0; i < 4; i++) bv[i] = 1'b1;
    drive_inputs();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_ready: got ready=%b busy=%b want 000000 0", req_ready, busy);
    end
    @(posedge clk); #1;
    rst  = 1'b0;
    m_rr = 0;
    n_cmp++;
    if (out_word() !== '0 || dbg_rr_ptr !== 3'd0) begin
      n_err++;
      $display("FAIL midrst_ports: got ports=%h rr=%0d want 0 0", out_word(), dbg_rr_ptr);
    end
    n_cmp++;
    if (busy !== EXP_BUSY_RST) begin
      n_err++;
      $display("FAIL midrst_busy: got %b want %b", busy, EXP_BUSY_RST);
    end
    clear_reqs();
`ifdef RF_SCHED_CLEAR_EN
    wait_sweep();
`endif
    bv[3] = 1'b1; ba[3] = 5'd9; bd[3] = 32'hCAFE_0003;
    cycle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_reqs();
    test_reset();
    test_distinct();
    test_same_addr();
    test_starvation();
    test_random();
    test_back_to_back_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
